countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Loadable down-counter and timer; the consumer-side counterpart of the team's free-running up counter.
- Software or an FSM loads a 16-bit value, starts it, and it decrements once per prescaled tick.
- Signals terminal count with a one-cycle pulse and a sticky expired flag; auto-reload mode gives periodic events.
- Sits between control logic and event consumers (timeouts, periodic strobes).

Parameters:
WIDTH, 16, count/load/reload width
PRESCALE_W, 16, prescaler divisor width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
load_valid  in  1  load request
load_value  in  WIDTH  value to load into count and reload register
load_ready  out  1  load can be accepted this cycle
prescale  in  PRESCALE_W  tick every prescale+1 clk cycles, sampled continuously
auto_reload  in  1  on terminal count, reload and keep running
start  in  1  begin or resume counting
stop  in  1  pause counting
count  out  WIDTH  current count value
busy  out  1  state == RUN
tc_pulse  out  1  one-cycle pulse on terminal count
expired  out  1  sticky; set on non-reload terminal count, cleared by load

Behaviour:
- Reset (async, takes effect immediately):
  - Outputs: count=0, busy=0, tc_pulse=0, expired=0, load_ready=1.
  - Internal: state=IDLE, reload register=0, prescaler pc=0.
- States: IDLE (never loaded), ARMED (loaded or paused), RUN, DONE.
- load_ready is combinational: 1 in IDLE, ARMED and DONE; 0 in RUN.
- Load is accepted when load_valid && load_ready. On the accepting edge:
  - count and reload register <= load_value.
  - pc <= 0, expired <= 0.
  - state <= ARMED.
- Start/stop:
  - start in ARMED -> RUN next edge.
  - start in IDLE, DONE or RUN: ignored.
  - stop in RUN -> ARMED next edge; count and pc held.
  - start and stop in the same cycle: stop wins; in ARMED, no transition.
  - load_valid in the same cycle as start in ARMED: load is taken and start is ignored.
- Prescaler:
  - In RUN, tick = (pc == prescale).
  - On a tick, pc <= 0; otherwise pc <= pc+1.
  - pc is held outside RUN.
  - prescale=0 gives a tick every RUN cycle.
  - If prescale changes below the current pc, pc wraps through its full range; this is legal and no check is made.
- RUN with count > 1 on a tick: count <= count-1.
- RUN with count == 1 on a tick (terminal count):
  - tc_pulse <= 1 for exactly one cycle.
  - If auto_reload && reload != 0: count <= reload, stay in RUN. Period is reload ticks.
  - Else: count <= 0, expired <= 1, state <= DONE.
- RUN entered with count == 0 (load of 0 then start):
  - On the first RUN cycle, tc_pulse <= 1, expired <= 1, state <= DONE.
  - count stays 0; the prescaler tick is not required.
- count never wraps below 0.
- DONE: count=0, expired=1; only a load exits DONE.
- Timing: with start accepted at edge E, busy=1 from edge E. With prescale=0, the first decrement occurs at edge E+1.
- tc_pulse is registered and coincides with the cycle in which count shows 0 or the reload value.
- Reset mid-RUN aborts immediately. No pulse is produced, and the reload value is lost.

Test Plan:
- Basic one-shot:
  - Stimulus: prescale=0, load 3, start.
  - Response: count 3,2,1,0 on consecutive cycles. tc_pulse high only in the cycle count=0. expired=1, busy=0, load_ready=1 from then on.
- Prescaled:
  - Stimulus: prescale=3, load 2, start.
  - Response: decrements 4 cycles apart; count 2 -> 1 -> 0 over 8 cycles; single tc_pulse.
- Auto-reload:
  - Stimulus: prescale=0, auto_reload=1, load 4, start, run 13 cycles.
  - Response: tc_pulse every 4 cycles (3 pulses). count sequence 3,2,1,4,3,... expired stays 0. stop returns to ARMED with count held.
- Pause/resume:
  - Stimulus: prescale=1, load 10, start, stop after 5 cycles, idle 6 cycles, start.
  - Response: count frozen during pause. pc phase preserved. Total RUN cycles to terminal count = 20.
- Edge cases:
  - Load 0 then start: tc_pulse one cycle, DONE, count 0.
  - start+stop in the same cycle from ARMED: stays ARMED.
  - load_valid in RUN: ignored (load_ready=0). start in DONE: ignored.
- Async reset mid-RUN:
  - Stimulus: load 0xFFFF, start, assert rst between clock edges.
  - Response: count=0, busy=0, expired=0 immediately, without a clock edge. load_ready=1 after release.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with terminal-count pulse,
// sticky expired flag and optional auto-reload.
//
// Ports:
//   clk, rst       clock (rising edge), async active-high reset
//   load_valid     load request; accepted when load_ready is high
//   load_value     value for count and the reload register
//   load_ready     high unless running
//   prescale       tick every prescale+1 clk cycles while running
//   auto_reload    on terminal count, reload and keep running
//   start, stop    begin/resume and pause; stop wins over start
//   count          current count value
//   busy           timer is running
//   tc_pulse       one-cycle pulse on terminal count
//   expired        sticky; set by one-shot terminal count, cleared by load
module countdown_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [WIDTH-1:0]      load_value,
  output logic                  load_ready,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  auto_reload,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [WIDTH-1:0]        count_n;
  logic [WIDTH-1:0]        reload;
  logic [WIDTH-1:0]        reload_n;
  logic [PRESCALE_W-1:0]   pc;
  logic [PRESCALE_W-1:0]   pc_n;
  logic                    tc_n;
  logic                    expired_n;
  logic                    take;
  logic                    tick;
  logic                    at_one;
  logic                    can_reload;

  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);
  assign take       = load_valid && load_ready;

  // prescale is sampled live; if it drops below pc the
  // prescaler simply wraps through its full range.
  assign tick       = (pc == prescale);
  assign at_one     = (count == WIDTH'(1));
  assign can_reload = auto_reload && (reload != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      pc       <= '0;
      tc_pulse <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      reload   <= reload_n;
      pc       <= pc_n;
      tc_pulse <= tc_n;
      expired  <= expired_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    pc_n      = pc;
    tc_n      = 1'b0;
    expired_n = expired;

    if (take) begin
      // A load in the same cycle as start wins; start is dropped.
      count_n   = load_value;
      reload_n  = load_value;
      pc_n      = '0;
      expired_n = 1'b0;
      state_n   = ARMED;
    end else begin
      unique case (state)
        ARMED: begin
          if (start && !stop)
            state_n = RUN;
        end
        RUN: begin
          if (stop) begin
            // Pause: count and prescaler phase are frozen.
            state_n = ARMED;
          end else if (count == '0) begin
            // Started from a zero load: expire at once,
            // without waiting for a prescaler tick.
            tc_n      = 1'b1;
            expired_n = 1'b1;
            state_n   = DONE;
          end else if (tick) begin
            pc_n = '0;
            if (at_one) begin
              tc_n = 1'b1;
              if (can_reload) begin
                count_n = reload;
              end else begin
                count_n   = '0;
                expired_n = 1'b1;
                state_n   = DONE;
              end
            end else begin
              count_n = count - WIDTH'(1);
            end
          end else begin
            pc_n = pc + PRESCALE_W'(1);
          end
        end
        IDLE, DONE: begin
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule
